set_assoc_cache_ctrl: RTL and testbench

//  Parametrised 2-way set-associative, write-through, no-write-allocate data cache with its own miss FSM.

---
 rtl/set_assoc_cache_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_ctrl.sv
// set_assoc_cache_ctrl: 2-way set-associative, write-through, no-write-allocate data cache
// placed between the MEM stage and the SRAM controller. A miss fills the whole line one word
// at a time over a ready-handshaked memory port and replaces the least recently used way.
// Optional feature macro: CACHE_STATS_EN adds saturating read hit/miss counters
// (stat_hits, stat_misses). The default build has no such ports.
module set_assoc_cache_ctrl #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 32,
    parameter int SET_LOG2  = 6,
    parameter int WORD_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
`endif
);

    localparam int TAG_W     = ADDR_W - SET_LOG2 - WORD_LOG2 - 2;
    localparam int SETS      = 1 << SET_LOG2;
    localparam int WORDS     = 1 << WORD_LOG2;
    localparam int OFF_W     = WORD_LOG2 + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    // Storage: tags and data are never cleared, only valid and LRU bits are.
    logic [TAG_W-1:0]  tag_mem  [2][SETS];
    logic [DATA_W-1:0] data_mem [2][SETS*WORDS];
    logic [SETS-1:0]   valid    [2];
    logic [SETS-1:0]   lru;

    logic [1:0]           state;
    logic                 fill_way;
    logic [WORD_LOG2-1:0] beat;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    wdata_reg;
    logic [DATA_W-1:0]    rdata_reg;

    logic [TAG_W-1:0]     cpu_tag;
    logic [SET_LOG2-1:0]  cpu_idx;
    logic [WORD_LOG2-1:0] cpu_word;
    logic [TAG_W-1:0]     req_tag;
    logic [SET_LOG2-1:0]  req_idx;
    logic [WORD_LOG2-1:0] req_word;

    logic                 hit0;
    logic                 hit1;
    logic                 hit;
    logic                 hit_way;
    logic [DATA_W-1:0]    hit_data;
    logic                 victim;
    logic                 rd_req;
    logic                 last_beat;
    logic                 unused_addr_bits;

    assign cpu_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
    assign cpu_idx  = cpu_addr[OFF_W +: SET_LOG2];
    assign cpu_word = cpu_addr[2 +: WORD_LOG2];
    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: SET_LOG2];
    assign req_word = req_addr[2 +: WORD_LOG2];

    // The byte-select bits of the CPU address play no part in a word cache.
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Way 0 takes priority if both ways ever matched the same tag.
    assign hit0      = valid[0][cpu_idx] && (tag_mem[0][cpu_idx] == cpu_tag);
    assign hit1      = valid[1][cpu_idx] && (tag_mem[1][cpu_idx] == cpu_tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = !hit0;
    assign hit_data  = data_mem[hit_way][{cpu_idx, cpu_word}];
    assign victim    = !valid[0][cpu_idx] ? 1'b0 :
                       (!valid[1][cpu_idx] ? 1'b1 : lru[cpu_idx]);
    assign rd_req    = cpu_rd_en && !cpu_wr_en;
    assign last_beat = &beat;

    // Output decode: everything idles at zero unless the current state drives it.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (rd_req && hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = hit_data;
                end
            end
            FILL: begin
                mem_rd_en = 1'b1;
                mem_addr  = {req_addr[ADDR_W-1:OFF_W], beat, 2'b00};
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_reg;
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = req_addr;
                mem_wdata = wdata_reg;
                cpu_ready = mem_ready;
            end
            default: ;
        endcase
    end

    // Miss/write FSM plus valid and LRU bookkeeping; reset abandons any fill in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid[0]  <= '0;
            valid[1]  <= '0;
            lru       <= '0;
            fill_way  <= 1'b0;
            beat      <= '0;
            req_addr  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr_en) begin
                        req_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        wdata_reg <= cpu_wdata;
                        state     <= WRITE;
                    end else if (cpu_rd_en) begin
                        if (hit) begin
                            lru[cpu_idx] <= !hit_way;
                        end else begin
                            req_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
                            fill_way <= victim;
                            beat     <= '0;
                            state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        if (beat == req_word) begin
                            rdata_reg <= mem_rdata;
                        end
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[fill_way][req_idx] <= 1'b1;
                            lru[req_idx]             <= !fill_way;
                            state                    <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (hit) begin
                            lru[cpu_idx] <= !hit_way;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data array writes: fill beats, the final tag, and write-through hit updates.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ready) begin
            data_mem[fill_way][{req_idx, beat}] <= mem_rdata;
            if (last_beat) begin
                tag_mem[fill_way][req_idx] <= req_tag;
            end
        end
        if (state == WRITE && mem_ready && hit) begin
            data_mem[hit_way][{cpu_idx, cpu_word}] <= wdata_reg;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating counters of completed read lookups: hits in IDLE, misses on entry to FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == IDLE && rd_req) begin
            if (hit) begin
                if (stat_hits != 16'hFFFF) begin
                    stat_hits <= stat_hits + 16'd1;
                end
            end else begin
                if (stat_misses != 16'hFFFF) begin
                    stat_misses <= stat_misses + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Testbench for set_assoc_cache_ctrl: directed scenarios plus randomized traffic checked
// against a recency-list cache model and a backing-memory model. Stats checks are built
// only when CACHE_STATS_EN is defined.
module tb_set_assoc_cache_ctrl;

    localparam int WORDS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    logic [18:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [18:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef CACHE_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    always #5 clk = ~clk;

    set_assoc_cache_ctrl dut (
        .clk(clk),
        .rst(rst),
        .cpu_rd_en(cpu_rd_en),
        .cpu_wr_en(cpu_wr_en),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits(stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    int checks = 0;
    int errors = 0;
    int mem_delay = 1;
    int wait_cnt = 0;
    logic [18:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [18:0] rd_addr_q [$];
    logic [18:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] mem_store [logic [18:0]];

    // Cache model: per set, the most and least recently used resident tags.
    int          mdl_cnt [64];
    logic [9:0]  mdl_mru [64];
    logic [9:0]  mdl_lru [64];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [18:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {13'h1A5, a};
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 64; i++) mdl_cnt[i] = 0;
    endfunction

    function automatic bit modelHit(input logic [18:0] a);
        int ix = int'(a[8:3]);
        return (mdl_cnt[ix] >= 1 && mdl_mru[ix] == a[18:9]) ||
               (mdl_cnt[ix] == 2 && mdl_lru[ix] == a[18:9]);
    endfunction

    function automatic void modelTouch(input logic [18:0] a);
        int ix = int'(a[8:3]);
        if (mdl_cnt[ix] == 2 && mdl_lru[ix] == a[18:9]) begin
            mdl_lru[ix] = mdl_mru[ix];
            mdl_mru[ix] = a[18:9];
        end
    endfunction

    function automatic void modelRead(input logic [18:0] a);
        int ix = int'(a[8:3]);
        if (modelHit(a)) begin
            modelTouch(a);
        end else if (mdl_cnt[ix] == 0) begin
            mdl_mru[ix] = a[18:9];
            mdl_cnt[ix] = 1;
        end else begin
            mdl_lru[ix] = mdl_mru[ix];
            mdl_mru[ix] = a[18:9];
            mdl_cnt[ix] = 2;
        end
    endfunction

    // Memory responder: answers each strobe after mem_delay cycles and watches its stability.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_rd_en || mem_wr_en) begin
                checkOutput("strobe_excl", 32'(mem_rd_en && mem_wr_en), 32'd0);
                if (wait_cnt == 0) begin
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                end else begin
                    checkOutput("addr_stable", 32'(mem_addr), 32'(cap_addr));
                    checkOutput("wdata_stable", mem_wdata, cap_wdata);
                end
                wait_cnt++;
                if (wait_cnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    if (mem_rd_en) begin
                        mem_rdata = memRead(mem_addr);
                        rd_addr_q.push_back(mem_addr);
                    end else begin
                        mem_store[mem_addr] = mem_wdata;
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                    end
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // One CPU request, held until cpu_ready; exp_hit 0/1 is a directed expectation, 2 = model.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [18:0] addr,
                                 input logic [31:0] wdata, input int exp_hit);
        bit          model_hit = modelHit(addr);
        bit          want_hit  = (exp_hit == 2) ? model_hit : exp_hit[0];
        logic [31:0] exp_data  = memRead({addr[18:2], 2'b00});
        logic [18:0] base      = {addr[18:3], 3'b000};
        int          exp_lat;
        int          samples   = 0;
        bit          seen      = 1'b0;
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        if (exp_hit != 2) checkOutput("model_agree", 32'(model_hit), 32'(want_hit));
        if (wr)            exp_lat = 1 + mem_delay;
        else if (want_hit) exp_lat = 1;
        else               exp_lat = 2 + WORDS * mem_delay;
        @(posedge clk);
        #2;
        cpu_rd_en = rd;
        cpu_wr_en = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        while (!seen && samples < 300) begin
            @(negedge clk);
            samples++;
            if (cpu_ready) seen = 1'b1;
        end
        checkOutput("ready_seen", 32'(seen), 32'd1);
        checkOutput(wr ? "wr_latency" : "rd_latency", 32'(samples), 32'(exp_lat));
        if (!wr) checkOutput("rd_data", cpu_rdata, exp_data);
        @(posedge clk);
        #2;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        if (wr) begin
            checkOutput("wr_beats", 32'(wr_addr_q.size()), 32'd1);
            checkOutput("rd_beats_on_wr", 32'(rd_addr_q.size()), 32'd0);
            if (wr_addr_q.size() == 1) begin
                checkOutput("wr_addr", 32'(wr_addr_q[0]), 32'({addr[18:2], 2'b00}));
                checkOutput("wr_data", wr_data_q[0], wdata);
            end
            if (model_hit) modelTouch(addr);
        end else begin
            checkOutput("fill_beats", 32'(rd_addr_q.size()), want_hit ? 32'd0 : 32'(WORDS));
            for (int k = 0; k < rd_addr_q.size() && k < WORDS; k++)
                checkOutput("fill_addr", 32'(rd_addr_q[k]), 32'(base + 19'(4 * k)));
            modelRead(addr);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        modelReset();
    endtask

    initial begin
        int n;
        logic [18:0] a;
        rst       = 1'b0;
        cpu_rd_en = 1'b1;
        cpu_wr_en = 1'b0;
        cpu_addr  = 19'h00100;
        cpu_wdata = '0;
        modelReset();
        mem_store[19'h00100] = 32'hA;
        mem_store[19'h00104] = 32'hB;

        // Reset state with a read request already presented.
        repeat (3) @(negedge clk);
        checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
        cpu_rd_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", 32'(cpu_ready), 32'd0);

        $display("[TB] basic fill and hit");
        mem_delay = 1;
        applyStimulus(1'b1, 1'b0, 19'h00100, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 19'h00104, 32'd0, 1);

        $display("[TB] LRU replacement in set 0");
        applyStimulus(1'b1, 1'b0, 19'h00200, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 19'h00400, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 19'h00200, 32'd0, 1);
        applyStimulus(1'b1, 1'b0, 19'h00600, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 19'h00200, 32'd0, 1);
        applyStimulus(1'b1, 1'b0, 19'h00400, 32'd0, 0);

        $display("[TB] write-through");
        applyStimulus(1'b0, 1'b1, 19'h00100, 32'h55, 1);
        applyStimulus(1'b1, 1'b0, 19'h00100, 32'd0, 1);
        applyStimulus(1'b0, 1'b1, 19'h7F000, 32'h1234_5678, 0);
        applyStimulus(1'b1, 1'b0, 19'h7F000, 32'd0, 0);

        // Five cycles per beat: 10 fill cycles + RESP, plus the IDLE lookup cycle.
        $display("[TB] slow memory");
        mem_delay = 5;
        applyStimulus(1'b1, 1'b0, 19'h01000, 32'd0, 0);

        $display("[TB] reset during fill");
        mem_delay = 3;
        a = 19'h0A000;
        rd_addr_q.delete();
        @(posedge clk);
        #2;
        cpu_rd_en = 1'b1;
        cpu_addr  = a;
        n = 0;
        while (rd_addr_q.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("beat0_done", 32'(rd_addr_q.size()), 32'd1);
        @(negedge clk);
        checkOutput("beat1_strobe", 32'(mem_rd_en), 32'd1);
        checkOutput("beat1_addr", 32'(mem_addr), 32'(a + 19'd4));
        rst = 1'b0;
        #1;
        checkOutput("abort_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("abort_ready", 32'(cpu_ready), 32'd0);
        checkOutput("abort_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        cpu_rd_en = 1'b0;
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b1, 1'b0, a, 32'd0, 0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 200; t++) begin
            logic [9:0]  tg = 10'($urandom_range(0, 3));
            logic [5:0]  ix = 6'($urandom_range(0, 3));
            logic        w  = 1'($urandom_range(0, 1));
            int          r  = int'($urandom_range(0, 99));
            mem_delay = int'($urandom_range(1, 3));
            a = {tg, ix, w, 2'b00};
            if (r < 60)      applyStimulus(1'b1, 1'b0, a, 32'd0, 2);
            else if (r < 90) applyStimulus(1'b0, 1'b1, a, $urandom, 2);
            else             applyStimulus(1'b1, 1'b1, a, $urandom, 2);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

`ifdef CACHE_STATS_EN
        $display("[TB] statistics counters");
        doReset();
        mem_delay = 1;
        applyStimulus(1'b1, 1'b0, 19'h04000, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 19'h04008, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 19'h04010, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 19'h04000, 32'd0, 1);
        applyStimulus(1'b1, 1'b0, 19'h04004, 32'd0, 1);
        applyStimulus(1'b1, 1'b0, 19'h04008, 32'd0, 1);
        applyStimulus(1'b1, 1'b0, 19'h04010, 32'd0, 1);
        @(negedge clk);
        checkOutput("stat_misses", 32'(stat_misses), 32'd3);
        checkOutput("stat_hits", 32'(stat_hits), 32'd4);
        @(posedge clk);
        #2;
        cpu_rd_en = 1'b1;
        cpu_addr  = 19'h04000;
        repeat (65540) @(posedge clk);
        #2;
        cpu_rd_en = 1'b0;
        @(negedge clk);
        checkOutput("stat_hits_sat", 32'(stat_hits), 32'h0000FFFF);
        checkOutput("stat_misses_hold", 32'(stat_misses), 32'd3);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
